// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings, FSM states and shared constants for pipe_ctrl.
package pipe_ctrl_pkg;
    localparam int STALL_W = 6;
    localparam logic [STALL_W-1:0] ZERO      = '0;
    localparam logic [STALL_W-1:0] STALL_PC  = 6'b000001;
    localparam logic [STALL_W-1:0] STALL_IF  = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX  = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM = 6'b011111;
    typedef enum logic [1:0] {RUN, DRAIN, FLUSH, REDIRECT} state_t;
endpackage

// File: rtl/pipe_ctrl_stall_merge.sv
// stall_merge: priority encoder from per-stage stall requests to the stall vector.
module stall_merge
    import pipe_ctrl_pkg::*;
(
    input  logic               req_if_i,
    input  logic               req_id_i,
    input  logic               req_ex_i,
    input  logic               req_mem_i,
    output logic [STALL_W-1:0] stall_o
);
    assign stall_o = req_mem_i ? STALL_MEM :
                     req_ex_i  ? STALL_EX  :
                     req_id_i  ? STALL_ID  :
                     req_if_i  ? STALL_IF  : ZERO;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, branch flush and interrupt entry sequencing (drain, flush, redirect).
// Optional PIPE_CTRL_STALL_CNT_EN adds per-cause saturating stall counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stallreq_if_i,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    input  logic               stallreq_mem_i,
    input  logic               branch_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               int_req_i,
    input  logic [ADDR_W-1:0]  mtvec_i,
    input  logic               mem_valid_i,
    input  logic               ex_valid_i,
    input  logic               id_valid_i,
    input  logic [ADDR_W-1:0]  mem_pc_i,
    input  logic [ADDR_W-1:0]  ex_pc_i,
    input  logic [ADDR_W-1:0]  id_pc_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               flush_int_o,
    output logic [ADDR_W-1:0]  new_pc_o,
    output logic               new_pc_valid_o,
    output logic               int_ack_o,
    output logic [ADDR_W-1:0]  mepc_o,
    output logic               mepc_we_o,
    output logic               drain_to_o
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    input  logic               stall_cnt_clr_i,
    output logic [127:0]       stall_cnt_o
`endif
);
    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [STALL_W-1:0] stall_req;
    logic [ADDR_W-1:0]  epc, mepc_q;
    logic               timeout;

    stall_merge u_merge (
        .req_if_i  (stallreq_if_i),
        .req_id_i  (stallreq_id_i),
        .req_ex_i  (stallreq_ex_i),
        .req_mem_i (stallreq_mem_i),
        .stall_o   (stall_req)
    );

    assign epc = mem_valid_i ? mem_pc_i : ex_valid_i ? ex_pc_i : id_valid_i ? id_pc_i : pc_i;

    always_comb begin
        state_d        = state_q;
        stall_o        = ZERO;
        flush_o        = 1'b0;
        flush_int_o    = 1'b0;
        new_pc_o       = '0;
        new_pc_valid_o = 1'b0;
        int_ack_o      = 1'b0;
        mepc_we_o      = 1'b0;
        timeout        = 1'b0;
        case (state_q)
            RUN, DRAIN: begin
                stall_o = (state_q == DRAIN) ? (stall_req | STALL_IF) : stall_req;
                if (branch_i && !stall_req[3]) begin
                    flush_o        = 1'b1;
                    new_pc_o       = branch_target_i;
                    new_pc_valid_o = 1'b1;
                end
                if (state_q == RUN) begin
                    state_d = int_req_i ? DRAIN : RUN;
                end else if (!int_req_i) begin
                    state_d = RUN;
                end else if (!stallreq_ex_i && !stallreq_mem_i) begin
                    state_d = FLUSH;
                end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
                    state_d = FLUSH;
                    timeout = 1'b1;
                end
            end
            FLUSH: begin
                flush_int_o = 1'b1;
                stall_o     = STALL_PC;
                mepc_we_o   = 1'b1;
                state_d     = REDIRECT;
            end
            default: begin
                new_pc_o       = mtvec_i;
                new_pc_valid_o = 1'b1;
                int_ack_o      = 1'b1;
                state_d        = RUN;
            end
        endcase
        // Everything combinational reads zero while reset is held.
        if (!rst_ni) begin
            stall_o        = ZERO;
            flush_o        = 1'b0;
            flush_int_o    = 1'b0;
            new_pc_o       = '0;
            new_pc_valid_o = 1'b0;
            int_ack_o      = 1'b0;
            mepc_we_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            mepc_q     <= '0;
            drain_to_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= (state_q == DRAIN) ? cnt_q + 1'b1 : '0;
            mepc_q     <= (state_q == FLUSH) ? epc : mepc_q;
            drain_to_o <= drain_to_o | timeout;
        end
    end

    // Shows the capture value during FLUSH, the held copy otherwise.
    assign mepc_o = (rst_ni && state_q == FLUSH) ? epc : mepc_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [3:0] win;
    assign win = {stallreq_mem_i,
                  stallreq_ex_i & ~stallreq_mem_i,
                  stallreq_id_i & ~stallreq_ex_i & ~stallreq_mem_i,
                  stallreq_if_i & ~stallreq_id_i & ~stallreq_ex_i & ~stallreq_mem_i};
    for (genvar i = 0; i < 4; i++) begin : g_cnt
        always_ff @(posedge clk_i) begin
            if (!rst_ni || stall_cnt_clr_i)
                stall_cnt_o[32*i +: 32] <= '0;
            else if (win[i] && stall_cnt_o[32*i +: 32] != '1)
                stall_cnt_o[32*i +: 32] <= stall_cnt_o[32*i +: 32] + 32'd1;
        end
    end
`endif
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control unit for the five-stage core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register, including the MEM/WB register. It issues branch flushes and sequences interrupt entry: drain, then `flush_int` pulse, then redirect to `mtvec`. It also captures `mepc` for the CSR unit.

## Interface
Parameters:
- `ADDR_W`, 32, PC width.
- `DRAIN_MAX`, 15, maximum cycles spent draining before the flush is forced (≥1).

Ports (one clock; reset is synchronous and active-low):
- `clk_i` input 1: core clock.
- `rst_ni` input 1: synchronous active-low reset.
- `stallreq_if_i` input 1: fetch bus wait.
- `stallreq_id_i` input 1: load-use hazard.
- `stallreq_ex_i` input 1: multicycle execute op (div) in progress.
- `stallreq_mem_i` input 1: data bus wait.
- `branch_i` input 1: taken branch/jump resolved in EX.
- `branch_target_i` input ADDR_W: branch target.
- `int_req_i` input 1: level interrupt request; held until `int_ack_o`.
- `mtvec_i` input ADDR_W: trap vector.
- `mem_valid_i`, `ex_valid_i`, `id_valid_i` input 1 each: stage holds a real instruction.
- `mem_pc_i`, `ex_pc_i`, `id_pc_i`, `pc_i` input ADDR_W each: stage PCs and current fetch PC.
- `stall_o` output 6: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
- `flush_o` output 1: branch flush of IF/ID and ID/EX.
- `flush_int_o` output 1: interrupt flush to all pipeline registers.
- `new_pc_o` output ADDR_W, `new_pc_valid_o` output 1: PC redirect.
- `int_ack_o` output 1: one-cycle interrupt acknowledge.
- `mepc_o` output ADDR_W, `mepc_we_o` output 1: mepc write to CSR unit.
- `drain_to_o` output 1: sticky flag, drain timed out.

## Operation
- Stall merge (combinational, highest stage wins): mem → 6'b011111; ex → 6'b001111; id → 6'b000111; if → 6'b000011; none → 0.
- FSM states: RUN, DRAIN, FLUSH, REDIRECT.
- RUN: `stall_o` = merged request.
  - If `branch_i` and `stall_o[3]`=0: `flush_o`=1, `new_pc_o`=`branch_target_i`, `new_pc_valid_o`=1 (same cycle).
  - If `int_req_i`=1: go to DRAIN and clear the drain counter.
- DRAIN: `stall_o` = merged request OR 6'b000011, so fetch freezes while older stages finish.
  - Branches are still honoured as in RUN.
  - Go to FLUSH when `stallreq_ex_i`=0 and `stallreq_mem_i`=0, or when the counter reaches DRAIN_MAX. On timeout, set `drain_to_o`.
- FLUSH (1 cycle): `flush_int_o`=1, `stall_o`=6'b000001, `mepc_we_o`=1.
  - `mepc_o` = oldest valid of `mem_pc_i`, `ex_pc_i`, `id_pc_i`; if none is valid, `pc_i`.
  - `branch_i` is ignored.
  - Next state: REDIRECT.
- REDIRECT (1 cycle): `new_pc_o`=`mtvec_i`, `new_pc_valid_o`=1, `int_ack_o`=1, `stall_o`=0. Next state: RUN.
- `int_req_i` deasserted during DRAIN: abort to RUN, no flush, no ack.
- `drain_to_o` clears only on reset.
- `mepc_o` holds its value between captures.

## Timing
- Reset (`rst_ni`=0 at a clock edge):
  - State becomes RUN; counters clear.
  - `mepc_o` and `drain_to_o` go to 0.
  - All combinational outputs read 0 during reset.
  - Reset mid-sequence (any state) returns to RUN with no ack.
- Latency with no outstanding stall:
  - `int_req_i` rising at edge n puts the FSM in DRAIN for cycle n+1.
  - FLUSH at n+2, REDIRECT at n+3, RUN at n+4.
  - Minimum interrupt entry is 3 cycles after the request is sampled.
- Timeout: with a stall held forever, FLUSH occurs exactly DRAIN_MAX cycles after DRAIN entry.
- Branch and interrupt in the same RUN cycle: the branch flush/redirect happens that cycle, and DRAIN starts next cycle.
- Branch while `stall_o[3]`=1: ignored; EX re-presents it later.
- All outputs other than `mepc_o`, `drain_to_o` and the counters are combinational from state and inputs.

## Configuration
- `PIPE_CTRL_STALL_CNT_EN`: compiles in four 32-bit saturating counters, one per stall cause, incremented when that cause wins the merge.
  - Exposed as `stall_cnt_o` output 128 (`[31:0]`=if … `[127:96]`=mem) and cleared by `stall_cnt_clr_i` input 1.
  - Without the macro, these ports and counters are absent.

## Structure
- Shared package (`defines.v`): `STALL_W`=6; the stall encodings `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`; FSM state constants; reuse of `ZERO`.
- One natural sub-module: `stall_merge`, the combinational priority encoder from stall requests to `stall_o`.
- Everything else stays in `pipe_ctrl`.

## Test plan
- Stall priority: `stallreq_id_i`=1 and `stallreq_mem_i`=1 together → `stall_o`=6'b011111; release mem → 6'b000111.
- Clean interrupt: all stages valid, `mem_pc_i`=0x100, `mtvec_i`=0x80 → `flush_int_o` at n+2, `mepc_o`=0x100, `new_pc_o`=0x80 with `int_ack_o` at n+3.
- Drain wait: `stallreq_mem_i` held 5 cycles after the request → FLUSH 1 cycle after release, `drain_to_o`=0.
- Timeout: `stallreq_ex_i` held, DRAIN_MAX=15 → FLUSH 15 cycles after DRAIN entry, `drain_to_o`=1 until reset.
- Branch + interrupt same cycle, target 0x200 → `flush_o`=1 and `new_pc_o`=0x200 that cycle; interrupt entry completes afterwards. With only `pc_i`=0x200 valid, `mepc_o`=0x200.
- Reset during DRAIN → RUN next cycle; `int_ack_o` never pulses; `mepc_o`=0.
